rom_loader: RTL
===============

ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 SHALL have port clock  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising edge of clock.
REQ-003 SHALL have port in_valid  input  1  upstream byte-stream valid.
REQ-004 SHALL have port in_byte  input  8  upstream byte, meaningful when in_valid=1.
REQ-005 SHALL have port in_ready  output  1  loader accepts byte; transfer occurs on a cycle where in_valid=1 and in_ready=1.
REQ-006 SHALL have port mem_write_enable  output  1  one-cycle write strobe to instruction memory.
REQ-007 SHALL have port mem_addr  output  `INST_ADDR_BUS  byte address of the word being written.
REQ-008 SHALL have port mem_data  output  `INST_DATA_BUS  instruction word being written.
REQ-009 SHALL have port cpu_reset  output  1  holds the CPU in reset while loading.
REQ-010 SHALL have port done  output  1  image fully loaded.
REQ-011 SHALL have port error  output  1  checksum mismatch; see Configuration.

Function
REQ-012 SHALL implement states HDR_HI, HDR_LO, DATA, CHECK, DONE.
REQ-013 HDR_HI: accepted byte -> count[15:8]; next HDR_LO.
REQ-014 HDR_LO: accepted byte -> count[7:0]; next DATA if count!=0, else CHECK (macro on) or DONE (macro off).
REQ-015 DATA: bytes assembled big-endian, first byte -> word[31:24], fourth byte -> word[7:0].
REQ-016 On the cycle after the fourth byte is accepted, SHALL assert mem_write_enable for exactly one cycle with mem_data = assembled word, mem_addr = current address.
REQ-017 Address SHALL start at 0 and advance by 4 after each write; 32-bit wrap-around is permitted, not flagged.
REQ-018 in_ready SHALL be 0 during the write-strobe cycle; throughput is one byte per cycle otherwise, so a word takes at least 5 cycles.
REQ-019 After the write of word number count, SHALL leave DATA (to CHECK or DONE); word counter is 16 bits, max image 65535 words.
REQ-020 in_ready SHALL be 1 in HDR_HI, HDR_LO, DATA (except strobe cycle), CHECK; 0 in DONE.
REQ-021 DONE is terminal until reset; bytes presented in DONE SHALL be ignored.
REQ-022 cpu_reset SHALL be 1 in every state except DONE; done SHALL be 1 only in DONE; both registered.
REQ-023 mem_data and mem_addr SHALL be stable while mem_write_enable=1; values outside the strobe are don't-care.
REQ-024 Idle cycles (in_valid=0) SHALL not change state or partial word.

Reset
REQ-025 On reset=1 at a clock edge: state HDR_HI, address 0, byte index 0, count 0, checksum 0, mem_write_enable 0, in_ready 0 for that cycle, cpu_reset 1, done 0, error 0.
REQ-026 Reset mid-load SHALL discard partial word and any pending strobe; no write issued on the reset cycle.

Configuration
REQ-027 Macro ROM_LOADER_CHECKSUM_EN: when defined, loader SHALL keep XOR of all DATA bytes and, in CHECK, accept one trailing byte; equal -> DONE with error=0, unequal -> DONE with error=1.
REQ-028 When ROM_LOADER_CHECKSUM_EN is undefined, CHECK state SHALL not exist, no trailing byte is consumed, error SHALL be constant 0.

Verification
REQ-029 Stream 00 01 12 34 56 78 -> one strobe, addr 0x00000000, data 0x12345678; done=1, cpu_reset=0 next cycle (macro off).
REQ-030 Stream 00 02 + 8 bytes with in_valid toggling every other cycle -> writes at addr 0x0 and 0x4 with correct words, no extra strobes.
REQ-031 Header 00 00 -> zero strobes; macro off: done right after header; macro on: waits one checksum byte 00 -> done, error=0.
REQ-032 Macro on, 00 01 AA BB CC DD + checksum 0x00 -> done=1, error=0; with checksum 0x01 -> done=1, error=1.
REQ-033 Reset asserted after 2 data bytes, then full stream 00 01 DE AD BE EF -> single write 0xDEADBEEF at addr 0x0.
REQ-034 After done, present 5 more bytes with in_valid=1 -> in_ready=0, no strobe, outputs unchanged.

Source files
------------

// File: rtl/rom_loader.sv
// Boot-time loader: takes a byte stream (16-bit word count header, big-endian words,
// optional XOR trailer when ROM_LOADER_CHECKSUM_EN is defined) and writes it into instruction memory.

`ifndef INST_ADDR_BUS
`define INST_ADDR_BUS 31:0
`endif
`ifndef INST_DATA_BUS
`define INST_DATA_BUS 31:0
`endif

module rom_loader (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_byte,
    output logic                  in_ready,
    output logic                  mem_write_enable,
    output logic [`INST_ADDR_BUS] mem_addr,
    output logic [`INST_DATA_BUS] mem_data,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error,
    output logic [2:0]            o_dbg_state
);

    // Handshake: a byte moves on a rising edge where in_valid=1 and in_ready=1;
    // in_ready is registered and drops for the single write-strobe cycle.
    typedef enum logic [2:0] {
        HDR_HI = 3'd0,
        HDR_LO = 3'd1,
        DATA   = 3'd2,
`ifdef ROM_LOADER_CHECKSUM_EN
        CHECK  = 3'd3,
`endif
        DONE   = 3'd4
    } state_t;

    state_t                r_state;
    logic [15:0]           r_count;
    logic [15:0]           r_words;
    logic [1:0]            r_byte_idx;
    logic [23:0]           r_partial;
    logic [`INST_ADDR_BUS] r_addr;
    logic [`INST_DATA_BUS] r_data;
    logic                  r_strobe;
    logic                  r_in_ready;
    logic                  r_cpu_reset;
    logic                  r_done;
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [7:0]            r_csum;
    logic                  r_error;
`endif

    logic        w_accept;
    logic [16:0] w_words_next;
    logic        w_last_word;
    logic [31:0] w_word_next;

    assign w_accept     = in_valid && r_in_ready;
    assign w_words_next = {1'b0, r_words} + 17'd1;
    assign w_last_word  = (w_words_next == {1'b0, r_count});
    assign w_word_next  = {r_partial, in_byte};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= HDR_HI;
            r_count     <= 16'd0;
            r_words     <= 16'd0;
            r_byte_idx  <= 2'd0;
            r_partial   <= 24'd0;
            r_addr      <= '0;
            r_data      <= '0;
            r_strobe    <= 1'b0;
            r_in_ready  <= 1'b0;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
            r_csum      <= 8'd0;
            r_error     <= 1'b0;
`endif
        end else begin
            r_strobe <= 1'b0;
            case (r_state)
                HDR_HI: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_count[15:8] <= in_byte;
                        r_state       <= HDR_LO;
                    end
                end

                HDR_LO: begin
                    if (w_accept) begin
                        r_count[7:0] <= in_byte;
                        if ({r_count[15:8], in_byte} != 16'd0) begin
                            r_state <= DATA;
                        end else begin
`ifdef ROM_LOADER_CHECKSUM_EN
                            r_state     <= CHECK;
`else
                            r_state     <= DONE;
                            r_in_ready  <= 1'b0;
                            r_done      <= 1'b1;
                            r_cpu_reset <= 1'b0;
`endif
                        end
                    end
                end

                DATA: begin
                    if (r_strobe) begin
                        // Strobe cycle: address moves on only after the write is presented.
                        r_addr  <= r_addr + 4;
                        r_words <= w_words_next[15:0];
                        if (w_last_word) begin
`ifdef ROM_LOADER_CHECKSUM_EN
                            r_state     <= CHECK;
                            r_in_ready  <= 1'b1;
`else
                            r_state     <= DONE;
                            r_in_ready  <= 1'b0;
                            r_done      <= 1'b1;
                            r_cpu_reset <= 1'b0;
`endif
                        end else begin
                            r_in_ready <= 1'b1;
                        end
                    end else if (w_accept) begin
                        r_partial <= w_word_next[23:0];
`ifdef ROM_LOADER_CHECKSUM_EN
                        r_csum    <= r_csum ^ in_byte;
`endif
                        if (r_byte_idx == 2'd3) begin
                            r_data     <= w_word_next;
                            r_strobe   <= 1'b1;
                            r_in_ready <= 1'b0;
                            r_byte_idx <= 2'd0;
                        end else begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                        end
                    end
                end

`ifdef ROM_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (w_accept) begin
                        r_error     <= (in_byte != r_csum);
                        r_state     <= DONE;
                        r_in_ready  <= 1'b0;
                        r_done      <= 1'b1;
                        r_cpu_reset <= 1'b0;
                    end
                end
`endif

                DONE: begin
                    r_in_ready <= 1'b0;
                end

                default: begin
                    r_state    <= HDR_HI;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready         = r_in_ready;
    assign mem_write_enable = r_strobe;
    assign mem_addr         = r_addr;
    assign mem_data         = r_data;
    assign cpu_reset        = r_cpu_reset;
    assign done             = r_done;
    assign o_dbg_state      = r_state;
`ifdef ROM_LOADER_CHECKSUM_EN
    assign error            = r_error;
`else
    assign error            = 1'b0;
`endif

endmodule
